// File: rtl/gpio_pkg.sv
// Shared register map and bus widths for the parametrised GPIO block.
// Also holds the request struct that the top decodes the bus strobes into.
package gpio_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] GPIO_IN      = 4'd0;
  localparam logic [ADDR_W-1:0] GPIO_OUT     = 4'd1;
  localparam logic [ADDR_W-1:0] GPIO_OUT_SET = 4'd2;
  localparam logic [ADDR_W-1:0] GPIO_OUT_CLR = 4'd3;
  localparam logic [ADDR_W-1:0] GPIO_OUT_TGL = 4'd4;
  localparam logic [ADDR_W-1:0] GPIO_DIR     = 4'd5;
  localparam logic [ADDR_W-1:0] GPIO_RISE_EN = 4'd6;
  localparam logic [ADDR_W-1:0] GPIO_FALL_EN = 4'd7;
  localparam logic [ADDR_W-1:0] GPIO_FLAGS   = 4'd8;

  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } gpio_req_t;
endpackage

// File: rtl/gpio_sync.sv
// Per-bit pad synchroniser: SYNC_STAGES flops deep, WIDTH bits wide.
// The last stage is the IN register seen by the bus and the edge detector.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_ctrl.sv
// Peribus GPIO slave: atomic output writes, per-pin direction, and
// rising/falling edge interrupt flags with write-1-to-clear.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  input  logic              read_en,
  input  logic              chipselect,
  output logic [DATA_W-1:0] read_data,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  bidir_port
);
  localparam int PRIME = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(PRIME + 1);

  gpio_req_t        req;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0] flags_q, flags_d, prev_q, in_sync;
  logic [WIDTH-1:0] wdata, clr_vec, set_vec;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic             irq_q, irq_d, primed;
  logic [CNT_W-1:0] prime_q, prime_d;
  logic             unused_wdata;

  assign unused_wdata = ^write_data;

  function automatic logic [DATA_W-1:0] zext(input logic [WIDTH-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // The pad is sampled even when we drive it, so toggles loop back as edges.
  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bidir_port),
    .q     (in_sync)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  always_comb begin
    req.wr    = chipselect & write_en;
    req.rd    = chipselect & read_en;
    req.addr  = addr;
    req.wdata = write_data;
    wdata     = req.wdata[WIDTH-1:0];

    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (req.wr) begin
      case (req.addr)
        GPIO_OUT:     out_d     = wdata;
        GPIO_OUT_SET: out_d     = out_q | wdata;
        GPIO_OUT_CLR: out_d     = out_q & ~wdata;
        GPIO_OUT_TGL: out_d     = out_q ^ wdata;
        GPIO_DIR:     dir_d     = wdata;
        GPIO_RISE_EN: rise_en_d = wdata;
        GPIO_FALL_EN: fall_en_d = wdata;
        default: ;
      endcase
    end

    // Edges are masked until the synchroniser has filled with real pad state.
    primed  = (prime_q == CNT_W'(PRIME));
    prime_d = primed ? prime_q : prime_q + CNT_W'(1);
    set_vec = primed ? ((in_sync & ~prev_q & rise_en_q) | (~in_sync & prev_q & fall_en_q))
                     : '0;
    clr_vec = (req.wr && req.addr == GPIO_FLAGS) ? wdata : '0;
    flags_d = (flags_q & ~clr_vec) | set_vec;
    irq_d   = |flags_q;

    rd_d = rd_q;
    if (req.rd) begin
      case (req.addr)
        GPIO_IN:                                          rd_d = zext(in_sync);
        GPIO_OUT, GPIO_OUT_SET, GPIO_OUT_CLR, GPIO_OUT_TGL: rd_d = zext(out_q);
        GPIO_DIR:                                         rd_d = zext(dir_q);
        GPIO_RISE_EN:                                     rd_d = zext(rise_en_q);
        GPIO_FALL_EN:                                     rd_d = zext(fall_en_q);
        GPIO_FLAGS:                                       rd_d = zext(flags_q);
        default:                                          rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flags_q   <= '0;
      prev_q    <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
      prime_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      flags_q   <= flags_d;
      prev_q    <= in_sync;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
      prime_q   <= prime_d;
    end
  end

  assign read_data = rd_q;
  assign irq       = irq_q;
endmodule
